pll_sampled_pfd: RTL

Sampled phase-frequency detector for the PLL loop. It sits directly downstream of the feedback frequency divider. It compares rising edges of the reference clock against the divided feedback clock, using the fast sampling clock `in` (VCO output), and produces UP/DN pulses for the charge-pump/loop-filter stage. It also reports a per-comparison phase-error magnitude and a lock indication.

---
 rtl/pll_pkg.sv | 15 +
 rtl/pll_sync_edge.sv | 28 ++
 rtl/pll_sampled_pfd.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pll_pkg.sv
// Shared types and default parameters for the sampled PLL phase detector.
package pll_pkg;

  typedef enum logic [1:0] {
    NEUTRAL = 2'd0,
    UP      = 2'd1,
    DN      = 2'd2
  } pfd_state_t;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int ERR_W_DEF       = 8;
  localparam int LOCK_TOL_DEF    = 2;
  localparam int LOCK_CNT_DEF    = 16;

endpackage

// File: rtl/pll_sync_edge.sv
// Synchronizer chain plus rising-edge detector for an asynchronous input.
module pll_sync_edge
  import pll_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] s;
  logic                   prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      s    <= '0;
      prev <= 1'b0;
    end else begin
      s    <= {s[SYNC_STAGES-2:0], d};
      prev <= s[SYNC_STAGES-1];
    end
  end

  assign rise = s[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/pll_sampled_pfd.sv
// Sampled phase-frequency detector with phase-error report and lock detect.
// Lock detector is built only when PLL_PFD_LOCK_DET_EN is defined.
module pll_sampled_pfd
  import pll_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int ERR_W       = ERR_W_DEF,
  parameter int LOCK_TOL    = LOCK_TOL_DEF,
  parameter int LOCK_CNT    = LOCK_CNT_DEF
) (
  input  logic             in,
  input  logic             rst,
  input  logic             ref_clk,
  input  logic             fb,
  output logic             up,
  output logic             dn,
  output logic [ERR_W-1:0] err,
  output logic             err_sign,
  output logic             err_valid,
  output logic             locked
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

  if (SYNC_STAGES < 2 || LOCK_CNT < 1 ||
      LOCK_TOL >= (1 << ERR_W) - 1) begin : g_bad_cfg
    $error("pll_sampled_pfd: invalid parameters");
  end

  logic       ref_rise;
  logic       fb_rise;
  pfd_state_t state;
  logic [ERR_W-1:0] cnt;

  // ref is a reserved word, hence ref_clk
  pll_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
    .clk  (in),
    .rst  (rst),
    .d    (ref_clk),
    .rise (ref_rise)
  );

  pll_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
    .clk  (in),
    .rst  (rst),
    .d    (fb),
    .rise (fb_rise)
  );

  always_ff @(posedge in) begin
    if (rst) begin
      state     <= NEUTRAL;
      up        <= 1'b0;
      dn        <= 1'b0;
      cnt       <= '0;
      err       <= '0;
      err_sign  <= 1'b0;
      err_valid <= 1'b0;
    end else begin
      err_valid <= 1'b0;
      unique case (state)
        NEUTRAL: begin
          unique case (1'b1)
            ref_rise & fb_rise: begin
              err_valid <= 1'b1;
              err       <= '0;
              err_sign  <= 1'b0;
            end
            ref_rise & ~fb_rise: begin
              state <= UP;
              up    <= 1'b1;
              cnt   <= ERR_ONE;
            end
            fb_rise & ~ref_rise: begin
              state <= DN;
              dn    <= 1'b1;
              cnt   <= ERR_ONE;
            end
            default: ;
          endcase
        end
        UP: begin
          // a second ref edge here is a frequency error; absorbed
          if (fb_rise) begin
            state     <= NEUTRAL;
            up        <= 1'b0;
            err_valid <= 1'b1;
            err       <= cnt;
            err_sign  <= 1'b0;
          end else if (cnt != ERR_MAX) begin
            cnt <= cnt + ERR_ONE;
          end
        end
        DN: begin
          if (ref_rise) begin
            state     <= NEUTRAL;
            dn        <= 1'b0;
            err_valid <= 1'b1;
            err       <= cnt;
            err_sign  <= 1'b1;
          end else if (cnt != ERR_MAX) begin
            cnt <= cnt + ERR_ONE;
          end
        end
        default: begin
          state <= NEUTRAL;
          up    <= 1'b0;
          dn    <= 1'b0;
        end
      endcase
    end
  end

`ifdef PLL_PFD_LOCK_DET_EN
  localparam int              LW      = $clog2(LOCK_CNT + 1);
  localparam logic [LW-1:0]   CNT_MAX = LW'(LOCK_CNT);
  localparam logic [ERR_W-1:0] TOL    = ERR_W'(LOCK_TOL);

  logic [LW-1:0] lock_cnt;
  logic [LW-1:0] lock_nxt;

  always_comb begin
    lock_nxt = lock_cnt;
    if (err_valid) begin
      if (err <= TOL) begin
        if (lock_cnt != CNT_MAX) lock_nxt = lock_cnt + LW'(1);
      end else begin
        lock_nxt = '0;
      end
    end
  end

  always_ff @(posedge in) begin
    if (rst) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      lock_cnt <= lock_nxt;
      locked   <= (lock_nxt == CNT_MAX);
    end
  end
`else
  assign locked = 1'b0;
`endif

endmodule
